// File: rtl/player_action_ctrl.sv
// Per-frame player movement/action controller: picks the action state each video frame
// and registers the motion steps and status flags that the position datapath consumes.
module player_action_ctrl #(
  parameter int unsigned JUMP_FRAMES   = 16,
  parameter int unsigned ATTACK_FRAMES = 10,
  parameter int unsigned DASH_FRAMES   = 8,
  parameter int unsigned DASH_COOLDOWN = 30,
  parameter int unsigned KNOCK_FRAMES  = 12
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       on_ground,
  input  logic       hit,
  input  logic       hit_dir,
  output logic [9:0] x_step,
  output logic [9:0] y_step,
  output logic [3:0] status,
  output logic       facing,
  output logic       attack_active,
  output logic       dash_ready
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WALK   = 4'd1,
    JUMP   = 4'd2,
    FALL   = 4'd3,
    ATTACK = 4'd4,
    DASH   = 4'd5,
    KNOCK  = 4'd6
  } state_t;

  localparam int unsigned CD_W = (DASH_COOLDOWN > 1) ? $clog2(DASH_COOLDOWN + 1) : 1;

  localparam logic [9:0] STEP_P2 = 10'd2;
  localparam logic [9:0] STEP_N2 = 10'h3FE;
  localparam logic [9:0] STEP_P3 = 10'd3;
  localparam logic [9:0] STEP_N3 = 10'h3FD;
  localparam logic [9:0] STEP_P4 = 10'd4;
  localparam logic [9:0] STEP_N4 = 10'h3FC;
  localparam logic [9:0] STEP_P6 = 10'd6;
  localparam logic [9:0] STEP_N6 = 10'h3FA;

  state_t            state, nxt_state;
  logic [5:0]        cnt, nxt_cnt;
  logic [CD_W-1:0]   cooldown, nxt_cd;
  logic [7:0]        prev_key;
  logic [9:0]        nxt_x, nxt_y, dir_x;
  logic              nxt_facing;
  logic              k_left, k_right, jump_edge, atk_edge, dash_ok, last_frame;
  state_t            land;

  always_comb begin
    k_left     = (keycode == 8'h50);
    k_right    = (keycode == 8'h4F);
    // Jump/attack only fire on the frame the key first appears, so holding never retriggers
    jump_edge  = (keycode == 8'h52) && (prev_key != 8'h52);
    atk_edge   = (keycode == 8'h1B) && (prev_key != 8'h1B);
    dash_ok    = (keycode == 8'h06) && (cooldown == '0);
    last_frame = (cnt <= 6'd1);
    land       = on_ground ? IDLE : FALL;
    dir_x      = k_left ? STEP_N2 : (k_right ? STEP_P2 : '0);

    nxt_state = state;
    unique case (state)
      IDLE, WALK: begin
        if (hit)             nxt_state = KNOCK;
        else if (!on_ground) nxt_state = FALL;
        else if (dash_ok)    nxt_state = DASH;
        else if (atk_edge)   nxt_state = ATTACK;
        else if (jump_edge)  nxt_state = JUMP;
        else if (k_left || k_right) nxt_state = WALK;
        else                 nxt_state = IDLE;
      end
      JUMP, FALL: begin
        if (hit)                             nxt_state = KNOCK;
        else if (dash_ok)                    nxt_state = DASH;
        else if (atk_edge)                   nxt_state = ATTACK;
        else if (state == JUMP && last_frame) nxt_state = FALL;
        else if (state == FALL && on_ground)  nxt_state = IDLE;
      end
      ATTACK, DASH: begin
        if (hit)             nxt_state = KNOCK;
        else if (last_frame) nxt_state = land;
      end
      KNOCK: if (last_frame) nxt_state = land;
      default: nxt_state = IDLE;
    endcase

    // The frame counter is loaded only on entry; staying in a timed state counts it down
    nxt_cnt = cnt;
    if (nxt_state != state) begin
      unique case (nxt_state)
        JUMP:    nxt_cnt = 6'(JUMP_FRAMES);
        ATTACK:  nxt_cnt = 6'(ATTACK_FRAMES);
        DASH:    nxt_cnt = 6'(DASH_FRAMES);
        KNOCK:   nxt_cnt = 6'(KNOCK_FRAMES);
        default: nxt_cnt = '0;
      endcase
    end else if (cnt != '0) begin
      nxt_cnt = cnt - 6'd1;
    end

    nxt_cd = cooldown;
    if (nxt_state == DASH && state != DASH) nxt_cd = CD_W'(DASH_COOLDOWN);
    else if (cooldown != '0)                nxt_cd = cooldown - CD_W'(1);

    nxt_facing = facing;
    if (nxt_state == WALK || nxt_state == JUMP || nxt_state == FALL) begin
      if (k_left)       nxt_facing = 1'b0;
      else if (k_right) nxt_facing = 1'b1;
    end

    nxt_x = '0;
    nxt_y = '0;
    unique case (nxt_state)
      WALK:   nxt_x = dir_x;
      JUMP:   begin nxt_x = dir_x; nxt_y = STEP_N4; end
      FALL:   begin nxt_x = dir_x; nxt_y = STEP_P4; end
      ATTACK: nxt_y = on_ground ? '0 : STEP_P4;
      DASH:   nxt_x = facing ? STEP_P6 : STEP_N6;
      KNOCK:  begin
        nxt_x = hit_dir ? STEP_N3 : STEP_P3;
        nxt_y = on_ground ? '0 : STEP_P4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cooldown      <= '0;
      prev_key      <= '0;
      x_step        <= '0;
      y_step        <= '0;
      facing        <= 1'b1;
      attack_active <= 1'b0;
      dash_ready    <= 1'b1;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      cooldown      <= nxt_cd;
      prev_key      <= keycode;
      x_step        <= nxt_x;
      y_step        <= nxt_y;
      facing        <= nxt_facing;
      attack_active <= (nxt_state == ATTACK);
      dash_ready    <= (nxt_cd == '0);
    end
  end

  assign status = state;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl: each step queues the expected registered outputs,
// clocks one frame, then pops and checks them with immediate assertions.
module tb_player_action_ctrl;

  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] kc = 8'h00;
  logic       og = 1'b1;
  logic       hit_s = 1'b0;
  logic       hd_s = 1'b0;
  logic [9:0] x_step, y_step;
  logic [3:0] status;
  logic       facing, attack_active, dash_ready;

  player_action_ctrl #(
    .JUMP_FRAMES(16), .ATTACK_FRAMES(10), .DASH_FRAMES(8),
    .DASH_COOLDOWN(30), .KNOCK_FRAMES(12)
  ) dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode(kc), .on_ground(og),
    .hit(hit_s), .hit_dir(hd_s), .x_step(x_step), .y_step(y_step),
    .status(status), .facing(facing), .attack_active(attack_active),
    .dash_ready(dash_ready)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string tag;
    int st; int x; int y; int f; int a; int r;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  function automatic int s10(int v);
    return v & 1023;
  endfunction

  // want < 0 marks a field as not checked at this point
  task automatic cmp(string tag, string fld, logic [31:0] obs, int want);
    if (want >= 0) begin
      n_assert++;
      assert (obs === 32'(want)) else begin
        n_fail++;
        $error("FAIL %s.%s got %0d want %0d", tag, fld, obs, want);
      end
    end
  endtask

  task automatic expect_out(string tag, int st, int x, int y, int f, int a, int r);
    exp_t e;
    e.tag = tag; e.st = st; e.x = x; e.y = y; e.f = f; e.a = a; e.r = r;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard got empty want entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "status", 32'(status), e.st);
    cmp(e.tag, "x_step", 32'(x_step), e.x);
    cmp(e.tag, "y_step", 32'(y_step), e.y);
    cmp(e.tag, "facing", 32'(facing), e.f);
    cmp(e.tag, "attack_active", 32'(attack_active), e.a);
    cmp(e.tag, "dash_ready", 32'(dash_ready), e.r);
  endtask

  task automatic step(string tag, logic [7:0] k, logic g, logic h, logic hd,
                      int st, int x, int y, int f, int a, int r);
    @(negedge frame_clk);
    kc = k; og = g; hit_s = h; hd_s = hd;
    expect_out(tag, st, x, y, f, a, r);
    @(posedge frame_clk);
    #1;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    repeat (2) @(posedge frame_clk);
    #1;
    expect_out("reset", 0, 0, 0, 1, 0, 1);
    pop_check();
    @(negedge frame_clk);
    Reset = 1'b0;

    // Jump: 16 frames up, then fall, then land
    step("jump_entry", 8'h52, 1, 0, 0, 2, 0, s10(-4), 1, 0, 1);
    for (int i = 1; i < 16; i++)
      step("jump_hold", 8'h00, 0, 0, 0, 2, 0, s10(-4), 1, 0, 1);
    step("jump_to_fall", 8'h00, 0, 0, 0, 3, 0, 4, 1, 0, 1);
    step("fall", 8'h00, 0, 0, 0, 3, 0, 4, 1, 0, 1);
    step("land", 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 1);

    // Walk left, dash left, cooldown gating
    step("walk_left", 8'h50, 1, 0, 0, 1, s10(-2), 0, 0, 0, 1);
    step("dash_entry", 8'h06, 1, 0, 0, 5, s10(-6), 0, 0, 0, 0);
    for (int i = 1; i < 8; i++)
      step("dash_hold", 8'h00, 1, 0, 0, 5, s10(-6), 0, 0, 0, 0);
    step("dash_exit", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 9; i < 20; i++)
      step("cooldown", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("dash_f20_ignored", 8'h06, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 21; i < 30; i++)
      step("cooldown", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("cooldown_done", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("dash_f31_taken", 8'h06, 1, 0, 0, 5, s10(-6), 0, 0, 0, 0);
    step("dash2_hold", 8'h00, 1, 0, 0, 5, s10(-6), 0, 0, 0, 0);

    // Hit during dash: 12 frames of knockback, extra hits ignored
    step("knock_entry", 8'h00, 1, 1, 1, 6, s10(-3), 0, 0, 0, 0);
    for (int i = 1; i < 12; i++)
      step("knock_hold", 8'h00, 1, (i == 5 || i == 11), 1, 6, s10(-3), 0, 0, 0, 0);
    step("knock_exit", 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, -1);

    // Attack held 40 frames gives one pulse; release and re-press gives another
    step("atk_entry", 8'h1B, 1, 0, 0, 4, 0, 0, 0, 1, -1);
    for (int i = 1; i < 10; i++)
      step("atk_hold", 8'h1B, 1, 0, 0, 4, 0, 0, 0, 1, -1);
    for (int i = 10; i < 40; i++)
      step("atk_held_idle", 8'h1B, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    step("atk_release", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    step("atk_repress", 8'h1B, 1, 0, 0, 4, 0, 0, 0, 1, -1);
    for (int i = 1; i < 10; i++)
      step("atk2_hold", 8'h00, 1, 0, 0, 4, 0, 0, 0, 1, -1);
    step("atk2_exit", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, -1);

    // Walking right off a ledge
    step("walk_right", 8'h4F, 1, 0, 0, 1, 2, 0, 1, 0, -1);
    step("ledge_fall", 8'h4F, 0, 0, 0, 3, 2, 4, 1, 0, -1);
    step("ledge_land", 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, -1);

    // Asynchronous reset in the middle of a jump
    step("jump6_entry", 8'h52, 1, 0, 0, 2, 0, s10(-4), 1, 0, -1);
    step("jump6_hold", 8'h00, 0, 0, 0, 2, 0, s10(-4), 1, 0, -1);
    @(negedge frame_clk);
    #2;
    Reset = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0, 1, 0, 1);
    pop_check();
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    step("post_reset", 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/player_action_ctrl.md
PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 SHALL have parameter JUMP_FRAMES, default 16, the number of frames of upward jump motion.
REQ-002 SHALL have parameter ATTACK_FRAMES, default 10, the number of frames of attack swing.
REQ-003 SHALL have parameter DASH_FRAMES, default 8, the number of frames of dash motion.
REQ-004 SHALL have parameter DASH_COOLDOWN, default 30, the number of frames after dash entry before the next dash is allowed.
REQ-005 SHALL have parameter KNOCK_FRAMES, default 12, the number of frames of knockback and invulnerability.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port frame_clk, input, 1 bit: clock, one rising edge per video frame.
REQ-008 SHALL have port keycode, input, 8 bits: USB keycode; 0x50 left, 0x4F right, 0x52 jump, 0x1B attack, 0x06 dash, any other value means none.
REQ-009 SHALL have port on_ground, input, 1 bit: player rests on the floor or platform (supplied by the position datapath).
REQ-010 SHALL have port hit, input, 1 bit: damage event, sampled each frame.
REQ-011 SHALL have port hit_dir, input, 1 bit: 1 means the attacker is on the right, so the push is to the left.
REQ-012 SHALL have port x_step, output, 10 bits: signed two's-complement X motion per frame.
REQ-013 SHALL have port y_step, output, 10 bits: signed two's-complement Y motion per frame; positive is down.
REQ-014 SHALL have port status, output, 4 bits: current state code.
REQ-015 SHALL have port facing, output, 1 bit: 1 means facing right.
REQ-016 SHALL have port attack_active, output, 1 bit: high during ATTACK.
REQ-017 SHALL have port dash_ready, output, 1 bit: high when the cooldown counter is 0.

Function
REQ-018 SHALL implement states IDLE=0, WALK=1, JUMP=2, FALL=3, ATTACK=4, DASH=5, KNOCK=6; status SHALL equal the state code.
REQ-019 SHALL register every output on the frame_clk rising edge; outputs SHALL reflect the state entered at that edge (1-frame latency from keycode/hit to step change).
REQ-020 SHALL apply this entry priority in IDLE/WALK: hit > !on_ground (to FALL) > dash (only if cooldown=0) > attack > jump (on_ground) > left/right > none.
REQ-021 In IDLE: x_step=0, y_step=0.
REQ-022 In WALK: x_step=-2 (left) or +2 (right), y_step=0; facing SHALL update to the key direction; with no key, SHALL go to IDLE.
REQ-023 JUMP SHALL load the frame counter with JUMP_FRAMES; y_step=-4; x_step=±2 while left/right is held, else 0 (facing updates); after exactly JUMP_FRAMES frames SHALL go to FALL.
REQ-024 In FALL: y_step=+4, x_step=±2 while left/right is held; when on_ground=1 SHALL go to IDLE with y_step=0 on that edge.
REQ-025 ATTACK SHALL last exactly ATTACK_FRAMES frames; attack_active=1; x_step=0; y_step=0 if on_ground, else +4; on exit SHALL go to IDLE if on_ground, else to FALL.
REQ-026 DASH SHALL last exactly DASH_FRAMES frames; x_step=+6 if facing=1, else -6; y_step=0 regardless of on_ground; on entry SHALL load cooldown with DASH_COOLDOWN; on exit SHALL go to IDLE or FALL as in REQ-025.
REQ-027 The cooldown counter SHALL decrement by 1 each frame while nonzero, in every state, and SHALL saturate at 0.
REQ-028 hit=1 in any state except KNOCK SHALL force KNOCK on the next edge, aborting JUMP/ATTACK/DASH.
REQ-029 KNOCK SHALL last exactly KNOCK_FRAMES frames; x_step=-3 if hit_dir=1, else +3; y_step=0 if on_ground, else +4; hit SHALL be ignored during KNOCK.
REQ-030 The KNOCK exit SHALL follow REQ-025.
REQ-031 A dash or attack key while in JUMP or FALL SHALL be accepted with the same priority (dash > attack).
REQ-032 The jump key in the air SHALL be ignored.
REQ-033 The frame counter SHALL be 6 bits wide.
REQ-034 Every *_FRAMES parameter SHALL be 1..63.
REQ-035 A state loaded with N SHALL exit on the edge at which the counter reaches 1.
REQ-036 A held key SHALL not retrigger ATTACK or JUMP until keycode has differed from that key for at least one frame (edge-qualified).
REQ-037 DASH SHALL be allowed whenever dash_ready=1.

Reset
REQ-038 While Reset=1, SHALL hold state=IDLE, x_step=0, y_step=0, facing=1, attack_active=0, frame counter=0, cooldown=0, dash_ready=1, and the edge-qualify latch cleared.
REQ-039 Reset asserted mid-operation (any state) SHALL take effect immediately, without waiting for a frame_clk edge.
REQ-040 After Reset deasserts, the first edge SHALL evaluate from IDLE.

Verification
REQ-041 SHALL cover: on_ground=1, keycode=0x52 for 1 frame → status=2 and y_step=-4 for 16 frames, then status=3 and y_step=+4; assert on_ground → status=0, y_step=0.
REQ-042 SHALL cover: keycode=0x50 → facing=0, x_step=-2 (0x3FE); keycode=0x06 → status=5, x_step=-6 for 8 frames; a second 0x06 at frame 20 → ignored; a 0x06 at frame 31 → dash accepted.
REQ-043 SHALL cover: keycode=0x1B held 40 frames → exactly one 10-frame attack_active pulse; release then re-press → a second pulse.
REQ-044 SHALL cover: in DASH, hit=1 with hit_dir=1 → next edge status=6, x_step=-3 for 12 frames; hit pulses during KNOCK → no restart.
REQ-045 SHALL cover: on_ground drops to 0 in WALK → status=3, y_step=+4 on the next edge.
REQ-046 SHALL cover: Reset pulsed mid-JUMP between clock edges → outputs reach reset values asynchronously.
